// File: rtl/wishbone_arbiter_2m1s.sv
// Two-master / one-slave Wishbone arbiter with round-robin tie break, grant held
// until the owning master drops cyc, and a per-transfer ack watchdog.
module wishbone_arbiter_2m1s #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SEL_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_data_i,
   input  logic [SEL_WIDTH-1:0]  m0_sel_i,
   output logic [DATA_WIDTH-1:0] m0_data_o,
   output logic                  m0_ack_o,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_data_i,
   input  logic [SEL_WIDTH-1:0]  m1_sel_i,
   output logic [DATA_WIDTH-1:0] m1_data_o,
   output logic                  m1_ack_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [ADDR_WIDTH-1:0] s_addr_o,
   output logic [DATA_WIDTH-1:0] s_data_o,
   output logic [SEL_WIDTH-1:0]  s_sel_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_ack_i,
   output logic [1:0]            gnt_o,
   output logic                  timeout_o
);

   // A disabled watchdog still needs a legal one-bit counter.
   localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2
   } arb_state_t;

   arb_state_t      state;
   arb_state_t      next_state;
   logic            last_gnt;
   logic [WD_W-1:0] wd_cnt;
   logic            wd_fire;
   logic            req0;
   logic            req1;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB_IDLE;
         last_gnt <= 1'b1;
      end else begin
         state <= next_state;
         if (state == ARB_GNT0 && next_state != ARB_GNT0) last_gnt <= 1'b0;
         if (state == ARB_GNT1 && next_state != ARB_GNT1) last_gnt <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ARB_IDLE: begin
            if (req0 && req1)  next_state = last_gnt ? ARB_GNT0 : ARB_GNT1;
            else if (req0)     next_state = ARB_GNT0;
            else if (req1)     next_state = ARB_GNT1;
         end
         ARB_GNT0: if (!m0_cyc_i) next_state = req1 ? ARB_GNT1 : ARB_IDLE;
         ARB_GNT1: if (!m1_cyc_i) next_state = req0 ? ARB_GNT0 : ARB_IDLE;
         default:  next_state = ARB_IDLE;
      endcase
   end

   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_addr_o = '0;
      s_data_o = '0;
      s_sel_o  = '0;
      if (state == ARB_GNT0) begin
         s_cyc_o  = m0_cyc_i;
         s_stb_o  = m0_stb_i;
         s_we_o   = m0_we_i;
         s_addr_o = m0_addr_i;
         s_data_o = m0_data_i;
         s_sel_o  = m0_sel_i;
      end else if (state == ARB_GNT1) begin
         s_cyc_o  = m1_cyc_i;
         s_stb_o  = m1_stb_i;
         s_we_o   = m1_we_i;
         s_addr_o = m1_addr_i;
         s_data_o = m1_data_i;
         s_sel_o  = m1_sel_i;
      end
   end

   // A real ack in the terminal-count cycle suppresses the fire.
   assign wd_fire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES))
                    && s_stb_o && !s_ack_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (state == ARB_IDLE || !s_stb_o || s_ack_i || wd_fire) begin
         wd_cnt <= '0;
      end else if (wd_cnt != '1) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign m0_ack_o  = (state == ARB_GNT0) && m0_stb_i && (s_ack_i || wd_fire);
   assign m1_ack_o  = (state == ARB_GNT1) && m1_stb_i && (s_ack_i || wd_fire);
   assign m0_data_o = (state == ARB_GNT0 && !wd_fire) ? s_data_i : '0;
   assign m1_data_o = (state == ARB_GNT1 && !wd_fire) ? s_data_i : '0;
   assign gnt_o     = {state == ARB_GNT1, state == ARB_GNT0};
   assign timeout_o = wd_fire;

endmodule

// File: tb/tb_wishbone_arbiter_2m1s.sv
// Bench for wishbone_arbiter_2m1s: one instance with a 4-cycle watchdog and one
// with the watchdog disabled, sharing all inputs.
module tb_wishbone_arbiter_2m1s;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [SW-1:0] m0_sel, m1_sel;
   logic [DW-1:0] s_rdata;
   logic          s_ack;

   logic [DW-1:0] m0_data_o, m1_data_o, s_data_o;
   logic          m0_ack_o, m1_ack_o, s_cyc_o, s_stb_o, s_we_o, timeout_o;
   logic [AW-1:0] s_addr_o;
   logic [SW-1:0] s_sel_o;
   logic [1:0]    gnt_o;

   logic [DW-1:0] nw_m0_data, nw_m1_data, nw_s_data;
   logic          nw_m0_ack, nw_m1_ack, nw_s_cyc, nw_s_stb, nw_s_we, nw_timeout;
   logic [AW-1:0] nw_s_addr;
   logic [SW-1:0] nw_s_sel;
   logic [1:0]    nw_gnt;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_d;

   wishbone_arbiter_2m1s #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
      .m0_data_i(m0_wdata), .m0_sel_i(m0_sel), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
      .m1_data_i(m1_wdata), .m1_sel_i(m1_sel), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
      .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_data_i(s_rdata), .s_ack_i(s_ack),
      .gnt_o(gnt_o), .timeout_o(timeout_o)
   );

   wishbone_arbiter_2m1s #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(0)) dut_nw (
      .clk(clk), .rst(rst),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
      .m0_data_i(m0_wdata), .m0_sel_i(m0_sel), .m0_data_o(nw_m0_data), .m0_ack_o(nw_m0_ack),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
      .m1_data_i(m1_wdata), .m1_sel_i(m1_sel), .m1_data_o(nw_m1_data), .m1_ack_o(nw_m1_ack),
      .s_cyc_o(nw_s_cyc), .s_stb_o(nw_s_stb), .s_we_o(nw_s_we), .s_addr_o(nw_s_addr),
      .s_data_o(nw_s_data), .s_sel_o(nw_s_sel), .s_data_i(s_rdata), .s_ack_i(s_ack),
      .gnt_o(nw_gnt), .timeout_o(nw_timeout)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_masters();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_sel = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_sel = '0;
   endtask

   task automatic m0_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      m0_cyc = 1; m0_stb = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_sel = s;
   endtask

   task automatic m1_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      m1_cyc = 1; m1_stb = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_sel = s;
   endtask

   task automatic apply_reset();
      rst = 1; s_ack = 0; s_rdata = '0; idle_masters();
      tick(); tick();
      rst = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1; s_ack = 0; s_rdata = '0; idle_masters();
      #3;
      checks++;
      if ({s_cyc_o, s_stb_o, s_we_o, gnt_o, m0_ack_o, m1_ack_o, timeout_o} !== 8'h00) begin
         errors++; $display("FAIL reset_ctrl got %b exp 0", {s_cyc_o, s_stb_o, s_we_o, gnt_o, m0_ack_o, m1_ack_o, timeout_o});
      end
      checks++;
      if ({s_addr_o, s_data_o, m0_data_o, m1_data_o} !== '0) begin
         errors++; $display("FAIL reset_data got %h %h %h %h exp 0", s_addr_o, s_data_o, m0_data_o, m1_data_o);
      end
      tick(); tick();
      rst = 0;
   endtask

   task automatic test_single_read();
      tick(); m0_req(0, 32'h100, '0, 4'hF); exp_q.push_back(32'hDEADBEEF);
      sample();
      checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL read_latency gnt got %b exp 00", gnt_o); end
      tick(); sample();
      checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL read_gnt got %b exp 01", gnt_o); end
      checks++; if (s_cyc_o !== 1'b1 || s_addr_o !== 32'h100) begin
         errors++; $display("FAIL read_bus cyc %b addr %h exp 1 00000100", s_cyc_o, s_addr_o); end
      tick(); sample();
      checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL read_early_ack got %b exp 0", m0_ack_o); end
      tick(); s_ack = 1; s_rdata = 32'hDEADBEEF; sample();
      checks++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL read_ack got %b exp 1", m0_ack_o); end
      exp_d = exp_q.pop_front();
      checks++; if (m0_data_o !== exp_d) begin errors++; $display("FAIL read_data got %h exp %h", m0_data_o, exp_d); end
      checks++; if (m1_ack_o !== 1'b0 || m1_data_o !== '0) begin
         errors++; $display("FAIL read_other ack %b data %h exp 0 0", m1_ack_o, m1_data_o); end
      tick(); s_ack = 0; s_rdata = '0; m0_cyc = 0; m0_stb = 0; sample();
      checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL read_release s_cyc got %b exp 0", s_cyc_o); end
      tick(); sample();
      checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL read_idle gnt got %b exp 00", gnt_o); end
   endtask

   task automatic test_tie();
      apply_reset();
      tick(); m0_req(0, 32'h200, '0, 4'hF); m1_req(0, 32'h300, '0, 4'hF);
      tick(); sample();
      checks++; if (gnt_o !== 2'b01 || s_addr_o !== 32'h200) begin
         errors++; $display("FAIL tie_first gnt %b addr %h exp 01 00000200", gnt_o, s_addr_o); end
      tick(); s_ack = 1; s_rdata = 32'h1111_1111; exp_q.push_back(32'h1111_1111); sample();
      exp_d = exp_q.pop_front();
      checks++; if (m0_ack_o !== 1'b1 || m0_data_o !== exp_d || m1_ack_o !== 1'b0) begin
         errors++; $display("FAIL tie_m0_ack ack %b data %h m1_ack %b exp 1 %h 0", m0_ack_o, m0_data_o, m1_ack_o, exp_d); end
      tick(); s_ack = 0; s_rdata = '0; m0_cyc = 0; m0_stb = 0; sample();
      checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL tie_dead_cycle s_cyc got %b exp 0", s_cyc_o); end
      tick(); sample();
      checks++; if (gnt_o !== 2'b10 || s_cyc_o !== 1'b1 || s_addr_o !== 32'h300) begin
         errors++; $display("FAIL tie_handoff gnt %b cyc %b addr %h exp 10 1 00000300", gnt_o, s_cyc_o, s_addr_o); end
      tick(); s_ack = 1; s_rdata = 32'h2222_2222; exp_q.push_back(32'h2222_2222); sample();
      exp_d = exp_q.pop_front();
      checks++; if (m1_ack_o !== 1'b1 || m1_data_o !== exp_d || m0_ack_o !== 1'b0) begin
         errors++; $display("FAIL tie_m1_ack ack %b data %h m0_ack %b exp 1 %h 0", m1_ack_o, m1_data_o, m0_ack_o, exp_d); end
      tick(); s_ack = 0; s_rdata = '0; m1_cyc = 0; m1_stb = 0;
      tick(); sample();
      checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL tie_idle gnt got %b exp 00", gnt_o); end
      tick(); m0_req(0, 32'h204, '0, 4'hF); m1_req(0, 32'h304, '0, 4'hF);
      tick(); sample();
      checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL tie_third gnt got %b exp 01", gnt_o); end
      tick(); idle_masters();
      tick();
   endtask

   task automatic test_write();
      tick(); m1_req(1, 32'h8000_0004, 32'h1234_5678, 4'b0011);
      tick(); sample();
      checks++; if (gnt_o !== 2'b10 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b1) begin
         errors++; $display("FAIL wr_ctrl gnt %b cyc %b stb %b we %b exp 10 1 1 1", gnt_o, s_cyc_o, s_stb_o, s_we_o); end
      checks++; if (s_addr_o !== 32'h8000_0004 || s_data_o !== 32'h1234_5678 || s_sel_o !== 4'b0011) begin
         errors++; $display("FAIL wr_pass addr %h data %h sel %b exp 80000004 12345678 0011", s_addr_o, s_data_o, s_sel_o); end
      tick(); s_ack = 1; sample();
      checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
         errors++; $display("FAIL wr_ack m1 %b m0 %b exp 1 0", m1_ack_o, m0_ack_o); end
      tick(); s_ack = 0; idle_masters();
      tick();
   endtask

   // ack_at_terminal: slave acks in the cycle the watchdog would otherwise fire
   task automatic test_watchdog(input bit ack_at_terminal);
      tick(); m0_req(0, 32'h400, '0, 4'hF); s_rdata = 32'hA5A5_A5A5;
      exp_q.push_back(ack_at_terminal ? 32'hCAFE_F00D : 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         sample();
         checks++; if (m0_ack_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++; $display("FAIL wd_wait%0d ack %b timeout %b exp 0 0", i, m0_ack_o, timeout_o); end
         tick();
      end
      if (ack_at_terminal) begin s_ack = 1; s_rdata = 32'hCAFE_F00D; end
      sample();
      exp_d = exp_q.pop_front();
      checks++; if (m0_ack_o !== 1'b1 || m0_data_o !== exp_d) begin
         errors++; $display("FAIL wd_ack%0d ack %b data %h exp 1 %h", ack_at_terminal, m0_ack_o, m0_data_o, exp_d); end
      checks++; if (timeout_o !== !ack_at_terminal) begin
         errors++; $display("FAIL wd_pulse%0d timeout got %b exp %b", ack_at_terminal, timeout_o, !ack_at_terminal); end
      checks++; if (nw_m0_ack !== ack_at_terminal || nw_timeout !== 1'b0) begin
         errors++; $display("FAIL wd_off_cmp ack %b timeout %b exp %b 0", nw_m0_ack, nw_timeout, ack_at_terminal); end
      tick(); s_ack = 0; s_rdata = '0; idle_masters();
      tick();
   endtask

   task automatic test_no_watchdog();
      int hits;
      hits = 0;
      tick(); m0_req(0, 32'h480, '0, 4'hF); s_rdata = 32'h5A5A_5A5A;
      tick(); sample();
      checks++; if (nw_gnt !== 2'b01) begin errors++; $display("FAIL nowd_gnt got %b exp 01", nw_gnt); end
      for (int i = 0; i < 20; i++) begin
         if (nw_m0_ack !== 1'b0 || nw_timeout !== 1'b0) hits++;
         tick(); sample();
      end
      checks++; if (hits !== 0) begin errors++; $display("FAIL nowd_ack cycles got %0d exp 0", hits); end
      tick(); s_rdata = '0; idle_masters();
      tick();
   endtask

   task automatic test_reset_mid();
      tick(); m1_req(0, 32'h500, '0, 4'hF);
      tick(); tick(); s_ack = 1; s_rdata = 32'h0000_0077;
      #1;
      checks++; if (m1_ack_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre ack got %b exp 1", m1_ack_o); end
      rst = 1;
      #1;
      checks++; if (s_cyc_o !== 1'b0 || gnt_o !== 2'b00 || m1_ack_o !== 1'b0) begin
         errors++; $display("FAIL rstmid_async cyc %b gnt %b ack %b exp 0 00 0", s_cyc_o, gnt_o, m1_ack_o); end
      tick(); rst = 0; s_ack = 0; s_rdata = '0; idle_masters();
      tick(); m0_req(0, 32'h600, '0, 4'hF); m1_req(0, 32'h700, '0, 4'hF);
      tick(); sample();
      checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rstmid_tie gnt got %b exp 01", gnt_o); end
      tick(); idle_masters();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_write();
      test_watchdog(0);
      test_watchdog(1);
      test_no_watchdog();
      test_reset_mid();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
